card_shoe: RTL and testbench

CARD_SHOE -- requirements
Module: card_shoe

---
 rtl/card_pkg.sv | 28 ++
 rtl/card_lfsr.sv | 32 +++
 rtl/card_shoe.sv | 143 ++++++++++++++
 tb/tb_card_shoe.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// Shared types and constants for the card shoe: rank encoding, FSM states
// and the small rank arithmetic helpers used by the scan logic.
package card_pkg;

  typedef logic [3:0] card_t;

  localparam card_t CARD_NONE = 4'd0;
  localparam card_t CARD_ACE  = 4'd1;
  localparam card_t CARD_KING = 4'd13;
  localparam int    NUM_RANKS = 13;
  localparam int    SUITS     = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // Map a random nibble 0..15 onto a starting rank 1..13 (values 13..15 fold to 1..3).
  function automatic card_t start_rank(input logic [3:0] l);
    return (l < 4'd13) ? (l + 4'd1) : (l - 4'd12);
  endfunction

  // Scan order is ace..king and then back round to ace.
  function automatic card_t next_rank(input card_t r);
    return (r == CARD_KING) ? CARD_ACE : (r + 4'd1);
  endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the shoe's
// randomness source. It never stalls, so the draw depends on request timing.
module card_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        slow_clock,
  input  logic        resetb,
  output logic [15:0] state
);

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] state_q;
  logic [15:0] state_d;
  logic        feedback;

  // Shift left, feeding the XOR of the tap bits into bit 0.
  always_comb begin
    feedback = state_q[15] ^ state_q[13] ^ state_q[12] ^ state_q[10];
    state_d  = {state_q[14:0], feedback};
  end

  // Advance every cycle; only reset reloads the seed.
  always_ff @(posedge slow_clock) begin
    if (!resetb) state_q <= SEED_EFF;
    else         state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/card_shoe.sv
// Card shoe: tracks how many cards of each rank remain and deals one card per
// request. A random start rank is chosen from the LFSR, then ranks are scanned
// one per cycle until a non-exhausted rank is found (at most 13 checks).
module card_shoe
  import card_pkg::*;
#(
  parameter int          NUM_DECKS = 1,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                              slow_clock,
  input  logic                              resetb,
  input  logic                              deal_req,
  input  logic                              shuffle,
  output logic [3:0]                        new_card,
  output logic                              card_valid,
  output logic                              busy,
  output logic [$clog2(52*NUM_DECKS+1)-1:0] cards_left,
  output logic                              empty,
  output logic                              err_empty
);

  localparam int CW = $clog2(SUITS*NUM_DECKS+1);
  localparam int LW = $clog2(NUM_RANKS*SUITS*NUM_DECKS+1);

  localparam logic [CW-1:0] RANK_FULL = CW'(SUITS*NUM_DECKS);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [LW-1:0] LEFT_FULL = LW'(NUM_RANKS*SUITS*NUM_DECKS);
  localparam logic [LW-1:0] LEFT_ONE  = LW'(1);

  state_t          state_q, state_d;
  card_t           rank_q, rank_d;
  card_t           new_card_q, new_card_d;
  logic            card_valid_q, card_valid_d;
  logic            err_empty_q, err_empty_d;
  logic [LW-1:0]   left_q, left_d;
  logic [CW-1:0]   count_q [NUM_RANKS];
  logic [CW-1:0]   count_d [NUM_RANKS];

  logic [15:0]     lfsr_state;
  logic            unused_lfsr_bits;
  logic [15:0]     rank_nonzero;
  logic [3:0]      rank_idx;
  logic            hit;
  logic            shoe_empty;

  card_lfsr #(.SEED(SEED)) u_lfsr (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .state      (lfsr_state)
  );

  // Only the low nibble picks the start rank; the rest just feeds the sequence.
  assign unused_lfsr_bits = ^lfsr_state[15:4];

  // One "still has cards" flag per rank, padded to 16 so any 4-bit index is safe.
  for (genvar gi = 0; gi < 16; gi++) begin : g_nonzero
    if (gi < NUM_RANKS) begin : g_rank
      assign rank_nonzero[gi] = (count_q[gi] != '0);
    end else begin : g_pad
      assign rank_nonzero[gi] = 1'b0;
    end
  end

  assign rank_idx   = rank_q - 4'd1;
  assign hit        = rank_nonzero[rank_idx];
  assign shoe_empty = (left_q == '0);

  // Next-state logic: shuffle always forces IDLE; a scan ends on the first hit.
  always_comb begin
    state_d = state_q;
    if (shuffle) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (deal_req && !shoe_empty) state_d = ST_SCAN;
        ST_SCAN: if (hit)                     state_d = ST_IDLE;
        default:                              state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath: counter reloads, scan stepping, card capture and error pulse.
  always_comb begin
    rank_d       = rank_q;
    new_card_d   = new_card_q;
    card_valid_d = 1'b0;
    err_empty_d  = 1'b0;
    left_d       = left_q;
    count_d      = count_q;
    if (shuffle) begin
      for (int i = 0; i < NUM_RANKS; i++) count_d[i] = RANK_FULL;
      left_d = LEFT_FULL;
    end else if (state_q == ST_IDLE) begin
      if (deal_req) begin
        if (shoe_empty) err_empty_d = 1'b1;
        else            rank_d      = start_rank(lfsr_state[3:0]);
      end
    end else begin
      if (hit) begin
        for (int i = 0; i < NUM_RANKS; i++) begin
          if (4'(i) == rank_idx) count_d[i] = count_q[i] - CNT_ONE;
        end
        left_d       = left_q - LEFT_ONE;
        new_card_d   = rank_q;
        card_valid_d = 1'b1;
      end else begin
        rank_d = next_rank(rank_q);
      end
    end
  end

  // State and datapath registers; reset overrides shuffle and any deal in flight.
  always_ff @(posedge slow_clock) begin
    if (!resetb) begin
      state_q      <= ST_IDLE;
      rank_q       <= CARD_ACE;
      new_card_q   <= CARD_NONE;
      card_valid_q <= 1'b0;
      err_empty_q  <= 1'b0;
      left_q       <= LEFT_FULL;
      for (int i = 0; i < NUM_RANKS; i++) count_q[i] <= RANK_FULL;
    end else begin
      state_q      <= state_d;
      rank_q       <= rank_d;
      new_card_q   <= new_card_d;
      card_valid_q <= card_valid_d;
      err_empty_q  <= err_empty_d;
      left_q       <= left_d;
      for (int i = 0; i < NUM_RANKS; i++) count_q[i] <= count_d[i];
    end
  end

  // Outputs: busy comes straight from the state, empty straight from the count.
  always_comb begin
    busy       = (state_q == ST_SCAN);
    new_card   = new_card_q;
    card_valid = card_valid_q;
    err_empty  = err_empty_q;
    cards_left = left_q;
    empty      = shoe_empty;
  end

endmodule

// File: tb/tb_card_shoe.sv
// Bench for card_shoe: a 1-deck and an 8-deck instance share one clock and
// reset. The reference model tracks remaining cards per rank and predicts
// each dealt rank and its latency from the LFSR nibble at the request edge.
module tb_card_shoe;

  logic       slow_clock = 1'b0;
  logic       resetb = 1'b0;
  logic       deal1 = 1'b0, shuf1 = 1'b0, deal8 = 1'b0, shuf8 = 1'b0;
  logic [3:0] card1, card8;
  logic       cv1, cv8, busy1, busy8, emp1, emp8, err1, err8;
  logic [5:0] left1;
  logic [8:0] left8;

  logic [15:0] ref_lfsr;
  int cnt  [2][14];
  int seen [2][14];
  int left_m [2];
  int n_checks = 0;
  int n_pass   = 0;

  always #5 slow_clock = ~slow_clock;

  card_shoe #(.NUM_DECKS(1), .SEED(16'hACE1)) dut (
    .slow_clock(slow_clock), .resetb(resetb), .deal_req(deal1), .shuffle(shuf1),
    .new_card(card1), .card_valid(cv1), .busy(busy1), .cards_left(left1),
    .empty(emp1), .err_empty(err1));

  card_shoe #(.NUM_DECKS(8), .SEED(16'hACE1)) dut8 (
    .slow_clock(slow_clock), .resetb(resetb), .deal_req(deal8), .shuffle(shuf8),
    .new_card(card8), .card_valid(cv8), .busy(busy8), .cards_left(left8),
    .empty(emp8), .err_empty(err8));

  // Reference LFSR: x^16+x^14+x^13+x^11, stepping every edge from the seed.
  always @(posedge slow_clock) begin
    if (!resetb) ref_lfsr <= 16'hACE1;
    else         ref_lfsr <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int cv_of(input int w);   return w ? int'(cv8)   : int'(cv1);   endfunction
  function automatic int card_of(input int w); return w ? int'(card8) : int'(card1); endfunction
  function automatic int left_of(input int w); return w ? int'(left8) : int'(left1); endfunction
  function automatic int emp_of(input int w);  return w ? int'(emp8)  : int'(emp1);  endfunction

  task automatic set_deal(input int w, input logic v);
    if (w == 0) deal1 = v; else deal8 = v;
  endtask

  task automatic model_full(input int w);
    for (int r = 1; r <= 13; r++) cnt[w][r] = w ? 32 : 4;
    left_m[w] = w ? 416 : 52;
  endtask

  task automatic clear_seen();
    for (int w = 0; w < 2; w++) for (int r = 0; r < 14; r++) seen[w][r] = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge slow_clock);
  endtask

  // One deal request; expected rank is the first rank with cards left, scanning
  // upward (wrapping) from the LFSR-derived start; latency = checks needed.
  task automatic deal_one(input int w);
    int l, s, r, exp_r, exp_lat, lat;
    l = int'(ref_lfsr[3:0]);
    s = (l % 13) + 1;
    exp_r = 0; exp_lat = 0;
    for (int k = 0; k < 13; k++) begin
      r = ((s - 1 + k) % 13) + 1;
      if (exp_r == 0 && cnt[w][r] > 0) begin exp_r = r; exp_lat = k + 1; end
    end
    set_deal(w, 1'b1);
    @(posedge slow_clock); @(negedge slow_clock);
    set_deal(w, 1'b0);
    lat = 0;
    for (int i = 1; i <= 14 && lat == 0; i++) begin
      @(posedge slow_clock); @(negedge slow_clock);
      if (cv_of(w) != 0) lat = i;
    end
    check_val("deal_latency", lat, exp_lat);
    check_val("deal_rank", card_of(w), exp_r);
    if (exp_r != 0) begin
      cnt[w][exp_r]--; left_m[w]--; seen[w][exp_r]++;
    end
    check_val("deal_cards_left", left_of(w), left_m[w]);
    check_val("deal_empty", emp_of(w), int'(left_m[w] == 0));
  endtask

  task automatic reset_check();
    resetb = 1'b0;
    repeat (2) @(posedge slow_clock);
    @(negedge slow_clock);
    check_val("rst_new_card", int'(card1), 0);
    check_val("rst_card_valid", int'(cv1), 0);
    check_val("rst_busy", int'(busy1), 0);
    check_val("rst_cards_left", int'(left1), 52);
    check_val("rst_empty", int'(emp1), 0);
    check_val("rst_cards_left8", int'(left8), 416);
    resetb = 1'b1;
    model_full(0); model_full(1);
  endtask

  task automatic watch_no_valid(input string tag, input int cycles);
    int pulses;
    pulses = int'(cv1);
    for (int i = 0; i < cycles; i++) begin
      @(posedge slow_clock); @(negedge slow_clock);
      pulses += int'(cv1);
    end
    check_val(tag, pulses, 0);
  endtask

  initial begin
    int prev_card;
    @(negedge slow_clock);
    reset_check();

    // Full single deck with random idle gaps between requests.
    clear_seen();
    for (int n = 0; n < 52; n++) begin
      idle($urandom_range(0, 3));
      deal_one(0);
    end
    for (int r = 1; r <= 13; r++) check_val($sformatf("deck1_rank%0d_count", r), seen[0][r], 4);
    check_val("deck1_cards_left", int'(left1), 0);
    check_val("deck1_empty", int'(emp1), 1);

    // Request against an empty shoe.
    prev_card = int'(card1);
    deal1 = 1'b1;
    @(posedge slow_clock); @(negedge slow_clock);
    deal1 = 1'b0;
    check_val("emptyreq_err_pulse", int'(err1), 1);
    check_val("emptyreq_busy", int'(busy1), 0);
    check_val("emptyreq_valid", int'(cv1), 0);
    @(posedge slow_clock); @(negedge slow_clock);
    check_val("emptyreq_err_cleared", int'(err1), 0);
    check_val("emptyreq_valid_after", int'(cv1), 0);
    check_val("emptyreq_busy_after", int'(busy1), 0);
    check_val("emptyreq_card_held", int'(card1), prev_card);

    // Shuffle recovery.
    shuf1 = 1'b1;
    @(posedge slow_clock); @(negedge slow_clock);
    shuf1 = 1'b0;
    model_full(0);
    check_val("shuffle_cards_left", int'(left1), 52);
    check_val("shuffle_empty", int'(emp1), 0);
    check_val("shuffle_card_held", int'(card1), prev_card);
    deal_one(0);
    check_val("shuffle_card_range", int'(card1 >= 4'd1 && card1 <= 4'd13), 1);

    // deal_req and shuffle together: shuffle wins, request dropped.
    repeat (3) deal_one(0);
    deal1 = 1'b1; shuf1 = 1'b1;
    @(posedge slow_clock); @(negedge slow_clock);
    deal1 = 1'b0; shuf1 = 1'b0;
    model_full(0);
    check_val("collide_busy", int'(busy1), 0);
    watch_no_valid("collide_no_valid", 14);
    check_val("collide_cards_left", int'(left1), 52);
    reset_check();

    // Shuffle while scanning aborts the deal.
    repeat (2) deal_one(0);
    deal1 = 1'b1;
    @(posedge slow_clock); @(negedge slow_clock);
    deal1 = 1'b0;
    check_val("abort_busy_in_scan", int'(busy1), 1);
    shuf1 = 1'b1;
    @(posedge slow_clock); @(negedge slow_clock);
    shuf1 = 1'b0;
    check_val("abort_busy_cleared", int'(busy1), 0);
    watch_no_valid("abort_no_valid", 14);
    check_val("abort_cards_left", int'(left1), 52);
    reset_check();

    // Reset while scanning aborts the deal and refills the shoe.
    repeat (2) deal_one(0);
    deal1 = 1'b1;
    @(posedge slow_clock); @(negedge slow_clock);
    deal1 = 1'b0;
    check_val("rstscan_busy_in_scan", int'(busy1), 1);
    resetb = 1'b0;
    @(posedge slow_clock); @(negedge slow_clock);
    check_val("rstscan_busy", int'(busy1), 0);
    check_val("rstscan_valid", int'(cv1), 0);
    check_val("rstscan_cards_left", int'(left1), 52);
    resetb = 1'b1;
    model_full(0); model_full(1);
    watch_no_valid("rstscan_no_valid", 3);
    reset_check();

    // Eight-deck shoe, dealt out completely.
    check_val("deck8_left_width", $bits(left8), 9);
    clear_seen();
    for (int n = 0; n < 416; n++) begin
      idle($urandom_range(0, 2));
      deal_one(1);
    end
    for (int r = 1; r <= 13; r++) check_val($sformatf("deck8_rank%0d_count", r), seen[1][r], 32);
    check_val("deck8_empty", int'(emp8), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
